a_skew_feeder: RTL and testbench

A_SKEW_FEEDER -- requirements
Module: a_skew_feeder

---
 rtl/tpu_pkg.sv | 13 +
 rtl/a_skew_row.sv | 49 ++++
 rtl/a_skew_feeder.sv | 125 ++++++++++++
 tb/tb_a_skew_feeder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default operand width and array size, and the
// feeder state encoding. The MAC array uses the same defaults.
package tpu_pkg;

  localparam int BITS_AB_DEF = 8;
  localparam int DIM_DEF     = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/a_skew_row.sv
// One skew chain of the A feeder. The chain is DIM+DELAY elements long and
// its head (element 0) feeds one row of the MAC array. A load places the
// row data behind DELAY leading zeros; a shift moves every element one
// place toward the head and brings a zero in at the tail.
module a_skew_row
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF,
  parameter int DELAY   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          shift,
  input  logic [DIM-1:0][BITS_AB-1:0]   din,
  output logic [BITS_AB-1:0]            head
);

  localparam int LEN = DIM + DELAY;

  logic [LEN-1:0][BITS_AB-1:0] chain_q;
  logic [LEN-1:0][BITS_AB-1:0] chain_d;

  // next chain contents: load (behind DELAY zeros) or shift toward the head
  always_comb begin
    chain_d = chain_q;
    if (load) begin
      chain_d = '0;
      for (int c = 0; c < DIM; c++) begin
        chain_d[DELAY + c] = din[c];
      end
    end else if (shift) begin
      chain_d = chain_q >> BITS_AB;
    end
  end

  // chain storage with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign head = chain_q[0];

endmodule

// File: rtl/a_skew_feeder.sv
// A-operand skew feeder for a DIM x DIM systolic MAC array. Rows of A are
// written while idle; a start pulse then streams them out diagonally so that
// row r lags row r-1 by one enabled cycle. A stream lasts 2*DIM-1 enabled
// cycles and consumes the loaded data.
//
// Optional build macro A_SKEW_ASSERT_EN compiles in protocol assertions
// (write/start while streaming, out-of-range row, done not a single pulse).
//
// state  | meaning
// IDLE   | rows may be written, waiting for start, Aout held at zero
// STREAM | chains shift on en, k counts enabled shifts, done on the last one
module a_skew_feeder
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                WrEn,
  input  logic [$clog2(DIM)-1:0]              Arow,
  input  logic signed [DIM-1:0][BITS_AB-1:0]  Ain,
  input  logic                                start,
  input  logic                                en,
  output logic signed [DIM-1:0][BITS_AB-1:0]  Aout,
  output logic                                busy,
  output logic                                done
);

  localparam int            KW     = $clog2(2 * DIM);
  localparam logic [KW-1:0] K_LAST = KW'(2 * DIM - 2);

  state_t           state_q;
  state_t           state_d;
  logic [KW-1:0]    k_q;
  logic [KW-1:0]    k_d;

  logic             shift_en;
  logic             wr_ok;
  logic [DIM-1:0]   row_load;
  logic [BITS_AB-1:0] head_w [DIM];

  // state and stream counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // next state: start leaves IDLE, the last enabled shift returns to it
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          k_d     = '0;
        end
      end
      STREAM: begin
        if (en) begin
          if (k_q == K_LAST) begin
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs and chain controls, all from registered state plus live inputs
  always_comb begin
    busy     = (state_q == STREAM);
    shift_en = busy && en;
    done     = shift_en && (k_q == K_LAST);
    // writes are only honoured in IDLE, so a same-cycle start still sees them
    wr_ok    = (state_q == IDLE) && WrEn && (int'(Arow) < DIM);
    row_load = '0;
    if (wr_ok) begin
      row_load[Arow] = 1'b1;
    end
    Aout = '0;
    if (busy) begin
      for (int r = 0; r < DIM; r++) begin
        Aout[r] = head_w[r];
      end
    end
  end

  // one chain per row, row r delayed by r
  for (genvar r = 0; r < DIM; r++) begin : g_row
    a_skew_row #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .DELAY   (r)
    ) u_row (
      .clk   (clk),
      .rst   (rst),
      .load  (row_load[r]),
      .shift (shift_en),
      .din   (Ain),
      .head  (head_w[r])
    );
  end

`ifdef A_SKEW_ASSERT_EN
  a_wren_in_stream : assert property (@(posedge clk) disable iff (rst) !(busy && WrEn))
    else $error("a_skew_feeder: WrEn while streaming");
  a_start_in_stream : assert property (@(posedge clk) disable iff (rst) !(busy && start))
    else $error("a_skew_feeder: start while streaming");
  a_arow_range : assert property (@(posedge clk) disable iff (rst) WrEn |-> (int'(Arow) < DIM))
    else $error("a_skew_feeder: Arow out of range");
  a_done_single : assert property (@(posedge clk) disable iff (rst) done |=> !done)
    else $error("a_skew_feeder: done held for more than one cycle");
`endif

endmodule

// File: tb/tb_a_skew_feeder.sv
// Bench for a_skew_feeder (DIM=4, BITS_AB=8) with a matrix-level reference
// model, plus a DIM=5 instance for the out-of-range row write.
module tb_a_skew_feeder;

  localparam int D  = 4;
  localparam int W  = 8;
  localparam int D5 = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            WrEn;
  logic [1:0]      Arow;
  logic [D*W-1:0]  Ain;
  logic            start;
  logic            en;
  logic [D*W-1:0]  Aout;
  logic            busy;
  logic            done;

  logic            rst5;
  logic            wr5;
  logic [2:0]      arow5;
  logic [D5*W-1:0] ain5;
  logic            start5;
  logic            en5;
  logic [D5*W-1:0] aout5;
  logic            busy5;
  logic            done5;

  always #5 clk = ~clk;

  a_skew_feeder #(.BITS_AB(W), .DIM(D)) dut (
    .clk(clk), .rst(rst), .WrEn(WrEn), .Arow(Arow), .Ain(Ain),
    .start(start), .en(en), .Aout(Aout), .busy(busy), .done(done)
  );

  a_skew_feeder #(.BITS_AB(W), .DIM(D5)) dut5 (
    .clk(clk), .rst(rst5), .WrEn(wr5), .Arow(arow5), .Ain(ain5),
    .start(start5), .en(en5), .Aout(aout5), .busy(busy5), .done(done5)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: the A matrix as written, a streaming flag and k
  logic [W-1:0] mem [D][D];
  bit           m_busy;
  int           m_k;

  function automatic void m_clear();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        mem[r][c] = '0;
  endfunction

  // Aout[r] = A[r][k-r] inside the diagonal window, zero elsewhere or idle
  function automatic logic [D*W-1:0] exp_aout();
    logic [D*W-1:0] v;
    v = '0;
    if (m_busy) begin
      for (int r = 0; r < D; r++) begin
        if (m_k - r >= 0 && m_k - r < D) v[r*W +: W] = mem[r][m_k - r];
      end
    end
    return v;
  endfunction

  // one clock: drive after negedge, check pre-edge outputs, advance model
  task automatic step(input logic wr, input logic [1:0] row, input logic [D*W-1:0] data,
                      input logic st, input logic e, input logic rs,
                      output logic [D*W-1:0] seen);
    @(negedge clk);
    WrEn = wr; Arow = row; Ain = data; start = st; en = e; rst = rs;
    #1;
    seen = Aout;
    chk("aout", Aout, exp_aout());
    chk("busy", busy, m_busy);
    chk("done", done, m_busy && e && (m_k == 2*D-2));
    @(posedge clk);
    if (rs) begin
      m_clear(); m_busy = 0; m_k = 0;
    end else if (!m_busy) begin
      if (wr) for (int c = 0; c < D; c++) mem[row][c] = data[c*W +: W];
      if (st) begin m_busy = 1; m_k = 0; end
    end else if (e) begin
      if (m_k == 2*D-2) begin
        m_busy = 0; m_k = 0; m_clear();
      end else begin
        m_k++;
      end
    end
  endtask

  logic [D*W-1:0] seen;

  task automatic load_std();
    logic [D*W-1:0] d;
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) d[c*W +: W] = W'(10*r + c);
      step(1'b1, 2'(r), d, 1'b0, 1'b1, 1'b0, seen);
    end
  endtask

  task automatic run_en(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, seen);
  endtask

  initial begin
    rst = 1; WrEn = 0; Arow = 0; Ain = '0; start = 0; en = 0;
    rst5 = 1; wr5 = 0; arow5 = 0; ain5 = '0; start5 = 0; en5 = 0;
    m_clear(); m_busy = 0; m_k = 0;
    repeat (2) @(posedge clk);

    // DIM=5: write to row 6 must be dropped, the stream stays all zero
    @(negedge clk);
    rst5 = 0; wr5 = 1; arow5 = 3'd6; ain5 = {8'h5A, 32'hA5C3_7E11};
    @(negedge clk);
    wr5 = 0; start5 = 1;
    #1;
    chk("d5_idle_busy", busy5, 1'b0);
    chk("d5_idle_aout", aout5, '0);
    @(negedge clk);
    start5 = 0; en5 = 1;
    for (int i = 0; i < 2*D5-1; i++) begin
      #1;
      chk("d5_aout", aout5, '0);
      chk("d5_busy", busy5, 1'b1);
      chk("d5_done", done5, (i == 2*D5-2));
      @(negedge clk);
    end
    en5 = 0;
    #1;
    chk("d5_end_busy", busy5, 1'b0);

    // reset state
    step(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1, seen);
    step(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, seen);

    // full stream with en held high
    load_std();
    step(1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, seen);
    for (int k = 0; k < 2*D-1; k++) begin
      step(1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, seen);
      if (k == 3) begin
        chk("s1_k3_row0", seen[7:0], 8'd3);
        chk("s1_k3_row3", seen[31:24], 8'd30);
      end
      if (k == 6) chk("s1_k6_row3", seen[31:24], 8'd33);
    end
    step(1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, seen);

    // en dropped for two cycles at k=2
    load_std();
    step(1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, seen);
    run_en(2);
    step(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, seen);
    step(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, seen);
    chk("s2_frozen_row1", seen[15:8], 8'd11);
    run_en(5);
    step(1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, seen);

    // write of row 1 in the same cycle as start
    step(1'b1, 2'd1, {8'hFC, 8'hFD, 8'hFE, 8'hFF}, 1'b1, 1'b1, 1'b0, seen);
    step(1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, seen);
    step(1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, seen);
    chk("s3_k1_row1", seen[15:8], 8'hFF);
    run_en(5);

    // write and second start mid-stream are ignored, then a zero stream
    load_std();
    step(1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, seen);
    run_en(3);
    step(1'b1, 2'd0, 32'h7777_7777, 1'b1, 1'b1, 1'b0, seen);
    run_en(3);
    step(1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, seen);
    for (int k = 0; k < 2*D-1; k++) begin
      step(1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, seen);
      if (k == 3) chk("s4_restream_zero", seen, '0);
    end

    // reset in the middle of a stream
    load_std();
    step(1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, seen);
    run_en(4);
    step(1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b1, seen);
    step(1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b0, seen);
    run_en(2*D-1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 3) == 0, 2'($urandom), $urandom,
           ($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 97) == 0, seen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
